// File: rtl/fp_argext.sv
// fp_argext: sequential arg-extremum finder over a stream of sign-magnitude
// fixed-point samples (Q15 by default; the comparison does not depend on Q).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               one-cycle pulse, begins a search and latches len/mode
//   mode                0 = maximum, 1 = minimum
//   len                 samples in the search, 0..MAXLEN (larger is clamped)
//   in_valid, in_data   sample stream, one sample per cycle with in_valid=1
//   busy                high while samples are being accepted
//   done                one-cycle pulse when the result is final
//   empty               result comes from a len=0 search
//   best_val, best_idx  extreme sample and its zero-based index
//
// Optional feature macro: FP_ARGEXT_ABS_EN adds input abs_sel (latched at
// start); with abs_sel=1 samples are ranked by magnitude only.
module fp_argext #(
    parameter int unsigned N      = 32,
    parameter int unsigned MAXLEN = 64,
    parameter int unsigned IW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef FP_ARGEXT_ABS_EN
    input  logic          abs_sel,
`endif
    input  logic          mode,
    input  logic [IW:0]   len,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          busy,
    output logic          done,
    output logic          empty,
    output logic [N-1:0]  best_val,
    output logic [IW-1:0] best_idx
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, state_d;
    logic [IW:0]   count, count_d;
    logic [IW:0]   len_q, len_d;
    logic          mode_q, mode_d;
    logic          abs_q, abs_d;
    logic          abs_start_c;
    logic          busy_d, done_d, empty_d;
    logic [N-1:0]  val_d;
    logic [IW-1:0] idx_d;
    logic [IW:0]   len_clamp_c;
    logic          better_c;

`ifdef FP_ARGEXT_ABS_EN
    assign abs_start_c = abs_sel;
`else
    assign abs_start_c = 1'b0;
`endif

    assign len_clamp_c = (len > (IW+1)'(MAXLEN)) ? (IW+1)'(MAXLEN) : len;

    // Sign-magnitude a > b; a zero magnitude counts as positive so -0 == +0.
    function automatic logic gt(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic ign_sign);
        logic          sa, sb;
        logic [N-2:0]  ma, mb;
        ma = a[N-2:0];
        mb = b[N-2:0];
        sa = a[N-1] & ~ign_sign & (ma != '0);
        sb = b[N-1] & ~ign_sign & (mb != '0);
        if (sa != sb) return sb;
        else if (!sa) return ma > mb;
        else          return ma < mb;
    endfunction

    assign better_c = mode_q ? gt(best_val, in_data, abs_q)
                             : gt(in_data, best_val, abs_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        count_d = count;
        len_d   = len_q;
        mode_d  = mode_q;
        abs_d   = abs_q;
        val_d   = best_val;
        idx_d   = best_idx;
        empty_d = empty;
        if (start) begin
            count_d = '0;
            len_d   = len_clamp_c;
            mode_d  = mode;
            abs_d   = abs_start_c;
            val_d   = '0;
            idx_d   = '0;
            if (len_clamp_c == '0) begin
                state_d = FIN;
                empty_d = 1'b1;
            end else begin
                state_d = RUN;
                empty_d = 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (in_valid) begin
                        // Index 0 always loads; later samples only on strict win.
                        if (count == '0 || better_c) begin
                            val_d = in_data;
                            idx_d = count[IW-1:0];
                        end
                        count_d = count + (IW+1)'(1);
                        if (count == len_q - (IW+1)'(1)) state_d = FIN;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            abs_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            empty    <= 1'b0;
            best_val <= '0;
            best_idx <= '0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            abs_q    <= abs_d;
            busy     <= busy_d;
            done     <= done_d;
            empty    <= empty_d;
            best_val <= val_d;
            best_idx <= idx_d;
        end
    end

endmodule

// File: tb/tb_fp_argext.sv
// tb_fp_argext: randomized plus directed bench for fp_argext with a
// queue-based reference model that rescans all accepted samples.
module tb_fp_argext;

    localparam int unsigned N      = 32;
    localparam int unsigned MAXLEN = 64;
    localparam int unsigned IW     = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abs_sel = 1'b0;
    logic          mode = 1'b0;
    logic [IW:0]   len = '0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          busy, done, empty;
    logic [N-1:0]  best_val;
    logic [IW-1:0] best_idx;

    int total = 0;
    int bad   = 0;

    fp_argext #(.N(N), .MAXLEN(MAXLEN), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef FP_ARGEXT_ABS_EN
        .abs_sel  (abs_sel),
`endif
        .mode     (mode),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .empty    (empty),
        .best_val (best_val),
        .best_idx (best_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] acc[$];
    bit           m_running = 0, m_done = 0, m_empty = 0, m_mode = 0, m_abs = 0;
    int           m_len = 0;
    logic [N-1:0] m_val = '0;
    int           m_idx = 0;
    bit           chk_en = 0;

    // Signed numeric value of a sign-magnitude word (magnitude only if absm).
    function automatic longint sval(input logic [N-1:0] w, input bit absm);
        longint mag;
        mag = longint'(w[N-2:0]);
        return (w[N-1] && !absm) ? -mag : mag;
    endfunction

    always @(posedge clk) begin
        chk_en = 1;
        if (rst) begin
            acc.delete();
            m_running = 0; m_done = 0; m_empty = 0; m_val = '0; m_idx = 0;
        end else if (start) begin
            acc.delete();
            m_len  = (int'(len) > MAXLEN) ? MAXLEN : int'(len);
            m_mode = mode;
`ifdef FP_ARGEXT_ABS_EN
            m_abs  = abs_sel;
`else
            m_abs  = 0;
`endif
            m_val = '0; m_idx = 0;
            m_empty   = (m_len == 0);
            m_running = (m_len != 0);
            m_done    = (m_len == 0);
        end else begin
            m_done = 0;
            if (m_running && in_valid) begin
                acc.push_back(in_data);
                m_idx = 0;
                for (int i = 1; i < acc.size(); i++) begin
                    if (m_mode ? (sval(acc[m_idx], m_abs) > sval(acc[i], m_abs))
                               : (sval(acc[i], m_abs) > sval(acc[m_idx], m_abs)))
                        m_idx = i;
                end
                m_val = acc[m_idx];
                if (acc.size() == m_len) begin
                    m_running = 0;
                    m_done    = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     32'(busy),     32'(m_running));
            check("done",     32'(done),     32'(m_done));
            check("empty",    32'(empty),    32'(m_empty));
            check("best_val", best_val,      m_val);
            check("best_idx", 32'(best_idx), 32'(m_idx));
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] stim[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit md, input int ln, input int gap, input bit ab);
        start = 1; mode = md; len = (IW+1)'(ln); abs_sel = ab; in_valid = 0;
        tick();
        start = 0;
        foreach (stim[i]) begin
            repeat (gap) begin in_valid = 0; tick(); end
            in_valid = 1; in_data = stim[i];
            tick();
        end
        in_valid = 0;
    endtask

    function automatic logic [N-1:0] rnd_sample();
        logic [N-1:0] w;
        if ($urandom_range(0, 2) == 0) w = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 3))};
        else                           w = $urandom;
        return w;
    endfunction

    initial begin
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_val",  best_val, 0);
        rst = 0;
        tick();

        // max with tie on 3.25 keeps index 2
        stim = '{32'h0000_4000, 32'h8001_0000, 32'h0001_A000, 32'h0001_A000, 32'h8000_0CCD};
        run(0, 5, 0, 0);
        check("t1_done", 32'(done), 1);
        check("t1_val",  best_val, 32'h0001_A000);
        check("t1_idx",  32'(best_idx), 2);
        tick();

        // min with repeated -3.0
        stim = '{32'h8000_8000, 32'h8001_8000, 32'h0001_0000, 32'h8001_8000};
        run(1, 4, 0, 0);
        check("t2_val", best_val, 32'h8001_8000);
        check("t2_idx", 32'(best_idx), 1);

        // -0 equals +0 in both modes
        stim = '{32'h0000_0000, 32'h8000_0000};
        run(1, 2, 0, 0);
        check("z1_val", best_val, 32'h0000_0000);
        check("z1_idx", 32'(best_idx), 0);
        stim = '{32'h8000_0000, 32'h0000_0000};
        run(0, 2, 1, 0);
        check("z0_val", best_val, 32'h8000_0000);
        check("z0_idx", 32'(best_idx), 0);

        // len=0 then back-to-back len=1
        stim.delete();
        run(0, 0, 0, 0);
        check("l0_done",  32'(done), 1);
        check("l0_empty", 32'(empty), 1);
        check("l0_val",   best_val, 0);
        stim = '{32'h8003_8000};
        run(0, 1, 0, 0);
        check("l1_done",  32'(done), 1);
        check("l1_empty", 32'(empty), 0);
        check("l1_val",   best_val, 32'h8003_8000);
        check("l1_idx",   32'(best_idx), 0);
        tick();

        // gapped full-length ramp
        stim.delete();
        for (int i = 0; i < MAXLEN; i++) stim.push_back(32'(i) << 8);
        run(0, MAXLEN, 2, 0);
        check("ramp_done", 32'(done), 1);
        check("ramp_idx",  32'(best_idx), MAXLEN - 1);
        check("ramp_val",  best_val, 32'h0000_3F00);
        tick();

        // reset mid-search, then restart mid-RUN
        stim = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
        run(0, 8, 0, 0);
        rst = 1; tick(); rst = 0;
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(done), 0);
        check("mr_val",  best_val, 0);
        check("mr_idx",  32'(best_idx), 0);
        stim = '{32'h7FFF_0000, 32'h7FFE_0000};
        run(0, 4, 0, 0);
        stim = '{32'h0000_0100, 32'h0000_0050};
        run(0, 2, 0, 0);
        check("ab_val", best_val, 32'h0000_0100);
        check("ab_idx", 32'(best_idx), 0);
        tick();

`ifdef FP_ARGEXT_ABS_EN
        stim = '{32'h0000_8000, 32'h8002_0000, 32'h0001_8000};
        run(0, 3, 0, 1);
        check("abs1_val", best_val, 32'h8002_0000);
        check("abs1_idx", 32'(best_idx), 1);
        run(0, 3, 0, 0);
        check("abs0_val", best_val, 32'h0001_8000);
        check("abs0_idx", 32'(best_idx), 2);
        tick();
`endif

        // randomized searches with aborts, resets and clamped lengths
        for (int s = 0; s < 250; s++) begin
            start = 1; mode = 1'($urandom_range(0, 1));
            len = (IW+1)'($urandom_range(0, 70));
            abs_sel = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1)); in_data = rnd_sample();
            tick();
            start = 0;
            for (int c = 0; c < 1000 && m_running; c++) begin
                int r;
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rnd_sample();
                r = int'($urandom_range(0, 299));
                if (r == 0) rst = 1;
                else if (r == 1) begin
                    start = 1; len = (IW+1)'($urandom_range(1, 70));
                end
                tick();
                rst = 0; start = 0;
            end
            if (m_running) check("rand_bound", 1, 0);
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1; in_data = rnd_sample();
                tick();
            end
            in_valid = 0;
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_argext.md
# fp_argext

Sequential fixed-point arg-extremum finder for the Codec2 encoder datapath. It streams up to MAXLEN sign-magnitude Q-format samples, one per accepted beat, and returns the extreme value and its zero-based index. The mode selects either maximum or minimum. It is the multi-sample, mode-selectable successor to the single-pair fixed-point greater-than comparator, and serves pitch-candidate, codebook-distance and LSP nearest-entry searches.

## Interface
- Q, 15, fractional bits (informational only; comparison is format-independent)
- N, 32, word width; bit N-1 is the sign, bits N-2:0 are the magnitude
- MAXLEN, 64, maximum samples per search
- IW, 6, index/count width; must satisfy 2^IW >= MAXLEN

- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous and active-high; one clock, all state cleared
- start  in  1  one-cycle pulse; begins a search, latches len and mode
- mode  in  1  0 = find maximum, 1 = find minimum (latched at start)
- len  in  IW+1  samples in this search, 0..MAXLEN (latched at start)
- in_valid  in  1  in_data is valid this cycle
- in_data  in  N  sample, sign-magnitude
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the result is final
- empty  out  1  result is from a len=0 search; held with the result
- best_val  out  N  extreme value found
- best_idx  out  IW  index of best_val within the stream

## Operation
- States: IDLE, RUN, FIN.
  - In IDLE or FIN, start moves to RUN: count=0, and len and mode are latched.
  - If latched len=0, go to FIN instead, with best_val=0, best_idx=0, empty=1.
  - In RUN, each cycle with in_valid=1 accepts one sample at index count, then count increments.
  - The sample with count == len-1 moves to FIN on the next edge.
  - FIN lasts one cycle with done=1, then returns to IDLE.
- Comparison uses sign-magnitude ordering:
  - Differing signs: the positive word is greater.
  - Both positive: the larger magnitude is greater.
  - Both negative: the smaller magnitude is greater.
  - -0 (sign 1, magnitude 0) equals +0.
  - Equal values are never "greater".
- Update rule:
  - The sample at index 0 is loaded unconditionally.
  - After that, replace best when sample > best (mode 0) or best > sample (mode 1).
  - Ties keep the earliest index.
- best_val, best_idx and empty hold their values until the next start or rst.
  - They update during RUN as samples are accepted.
  - They are final only when done=1.
- start during RUN aborts the current search and restarts immediately, with the same actions as start in IDLE.
- in_valid outside RUN is ignored.
- len > MAXLEN is clamped to MAXLEN at latch time.

## Timing
- Reset values: busy=0, done=0, empty=0, best_val=0, best_idx=0, state IDLE, count=0.
- start at edge k:
  - busy=1 from k+1.
  - The first sample can be accepted at edge k+1 (the sample presented in cycle k+1).
- Last sample accepted at edge m: done=1 and busy=0 during cycle m+1, and the result is valid in that cycle.
- len=0: done=1 in the cycle after the start edge.
- Back-to-back: start can be asserted during the FIN cycle, and the next search begins with no idle gap.
- The comparator is combinational on best vs in_data. There is one register stage, with no pipeline bubbles.
- Throughput is one sample per clock.
- rst mid-search: on the next edge, return to IDLE with all outputs at their reset values. No done is issued.

## Configuration
- FP_ARGEXT_ABS_EN:
  - When defined, adds input port abs_sel (1 bit, latched at start).
  - With abs_sel=1, the comparison ignores bit N-1 of both operands and ranks by magnitude only.
  - best_val still reports the original signed sample.
- When undefined: the port is absent and the comparison is always signed, as above.

## Test plan
- Mode 0, len=5, N=32, samples {+0.5, -2.0, +3.25, +3.25, -0.1} in Q15 -> done once, best_val=+3.25, best_idx=2 (tie keeps first).
- Mode 1, len=4, samples {-1.0, -3.0, +2.0, -3.0} -> best_val=-3.0, best_idx=1. Also check that -0 vs +0 is treated as equal (no replacement).
- len=0 start -> done=1 in the next cycle, empty=1, best_val=0, best_idx=0. Then start len=1 with {-7} -> empty=0, best_val=-7, best_idx=0.
- Gapped in_valid (one sample every 3 clocks), len=MAXLEN, with a ramp peak at index MAXLEN-1 -> best_idx=MAXLEN-1. done fires exactly one cycle after the last accepted beat.
- rst asserted after 3 of 8 samples -> next edge all outputs 0, no done. Restart with start mid-RUN -> the new search result ignores pre-restart samples.
- With FP_ARGEXT_ABS_EN, abs_sel=1, mode 0, samples {+1.0, -4.0, +3.0} -> best_val=-4.0, best_idx=1. With abs_sel=0 -> best_val=+3.0, best_idx=2.
